// File: rtl/pulse_monitor_pkg.sv
// Shared types and constants for the pulse_monitor block.
// Optional input filter is selected with `define PULSE_MONITOR_DEGLITCH_EN.
package pulse_monitor_pkg;

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    HIGH       = 2'd1,
    LOW        = 2'd2
  } pm_state_e;

  // Cycles a new synchronised level must persist before the filter accepts it.
  localparam int unsigned DEGLITCH_LEN = 3;

  localparam int unsigned DEFAULT_CNT_W = 16;

endpackage

// File: rtl/pulse_sync_edge.sv
// Synchroniser and edge detector for the asynchronous pulse input.
// With PULSE_MONITOR_DEGLITCH_EN defined, a 3-cycle persistence filter sits before the edge logic.
module pulse_sync_edge
  import pulse_monitor_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pulse_in,
  output logic rise,
  output logic fall
);

  localparam int unsigned FILL   = SYNC_STAGES + 1;
  localparam int unsigned FILL_W = $clog2(FILL + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   p_sync;
  logic [FILL_W-1:0]      fill_q;
  logic                   primed;
  logic                   level;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_in};
    end
  end

  assign p_sync = sync_q[SYNC_STAGES-1];

  // Edges are suppressed until the chain and prev flop hold sampled data, so a
  // level already high at reset release is not mistaken for a rise.
  assign primed = (fill_q == FILL_W'(FILL));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q <= '0;
    end else if (!primed) begin
      fill_q <= fill_q + FILL_W'(1);
    end
  end

`ifdef PULSE_MONITOR_DEGLITCH_EN
  localparam int unsigned GW = $clog2(DEGLITCH_LEN);

  logic [GW-1:0] hold_q;

  // The filtered level flips in the third consecutive cycle of disagreement.
  always_comb begin
    level = prev_q;
    if ((p_sync != prev_q) && (hold_q == GW'(DEGLITCH_LEN - 1))) begin
      level = p_sync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
      hold_q <= '0;
    end else if (!primed) begin
      prev_q <= p_sync;
      hold_q <= '0;
    end else begin
      prev_q <= level;
      hold_q <= (p_sync == level) ? '0 : hold_q + GW'(1);
    end
  end
`else
  assign level = p_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= p_sync;
    end
  end
`endif

  assign rise = primed & level & ~prev_q;
  assign fall = primed & ~level & prev_q;

endmodule

// File: rtl/pulse_monitor.sv
// Measures high width and period of a pulse stream and presents results on valid/ready.
// Define PULSE_MONITOR_DEGLITCH_EN to enable the input persistence filter.
module pulse_monitor
  import pulse_monitor_pkg::*;
#(
  parameter int unsigned CNT_W       = DEFAULT_CNT_W,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse_in,
  input  logic             meas_ready,
  output logic             meas_valid,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic [15:0]      pulse_count,
  output logic             overflow,
  output logic             timeout
);

  localparam int unsigned   IDLE_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic rise, fall;

  pulse_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .pulse_in(pulse_in),
    .rise    (rise),
    .fall    (fall)
  );

  pm_state_e         state_q, state_d;
  logic [CNT_W-1:0]  hi_q, hi_d, lo_q, lo_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [CNT_W-1:0]  high_q, high_d, period_q, period_d;
  logic [15:0]       count_q, count_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic              to_q, to_d;
  logic              capture, ovf_set;
  logic              hi_full, lo_full, idle_hit;
  logic [CNT_W:0]    sum_full;
  logic [CNT_W-1:0]  sum_sat;

  assign hi_full  = (hi_q == CNT_MAX);
  assign lo_full  = (lo_q == CNT_MAX);
  assign idle_hit = (idle_q == IDLE_W'(TIMEOUT - 1));
  assign sum_full = {1'b0, hi_q} + {1'b0, lo_q};
  assign sum_sat  = sum_full[CNT_W] ? CNT_MAX : sum_full[CNT_W-1:0];

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    idle_d  = idle_q;
    capture = 1'b0;
    ovf_set = 1'b0;
    to_d    = rise ? 1'b0 : to_q;

    unique case (state_q)
      WAIT_FIRST: begin
        if (rise) begin
          hi_d    = CNT_W'(1);
          lo_d    = '0;
          idle_d  = '0;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (fall) begin
          lo_d    = CNT_W'(1);
          idle_d  = '0;
          state_d = LOW;
        end else if (idle_hit) begin
          idle_d  = '0;
          to_d    = 1'b1;
          state_d = WAIT_FIRST;
        end else begin
          hi_d    = hi_full ? CNT_MAX : hi_q + CNT_W'(1);
          ovf_set = hi_full;
          idle_d  = idle_q + IDLE_W'(1);
        end
      end
      LOW: begin
        if (rise) begin
          capture = 1'b1;
          ovf_set = sum_full[CNT_W];
          hi_d    = CNT_W'(1);
          lo_d    = '0;
          idle_d  = '0;
          state_d = HIGH;
        end else if (idle_hit) begin
          idle_d  = '0;
          to_d    = 1'b1;
          state_d = WAIT_FIRST;
        end else begin
          lo_d    = lo_full ? CNT_MAX : lo_q + CNT_W'(1);
          ovf_set = lo_full;
          idle_d  = idle_q + IDLE_W'(1);
        end
      end
      default: state_d = WAIT_FIRST;
    endcase
  end

  // A new capture always wins over both holding and transfer.
  always_comb begin
    high_d   = high_q;
    period_d = period_q;
    count_d  = count_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q | ovf_set;
    if (capture) begin
      high_d   = hi_q;
      period_d = sum_sat;
      count_d  = count_q + 16'd1;
      valid_d  = 1'b1;
    end else if (valid_q && meas_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= WAIT_FIRST;
      hi_q     <= '0;
      lo_q     <= '0;
      idle_q   <= '0;
      high_q   <= '0;
      period_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      idle_q   <= idle_d;
      high_q   <= high_d;
      period_q <= period_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      to_q     <= to_d;
    end
  end

  assign meas_valid  = valid_q;
  assign high_cnt    = high_q;
  assign period_cnt  = period_q;
  assign pulse_count = count_q;
  assign overflow    = ovf_q;
  assign timeout     = to_q;

endmodule

// File: tb/tb_pulse_monitor.sv
// Directed bench for pulse_monitor: one 16-bit instance and one 4-bit instance, TIMEOUT=50.
// Build with PULSE_MONITOR_DEGLITCH_EN to exercise the filtered variant.
module tb_pulse_monitor;

`ifdef PULSE_MONITOR_DEGLITCH_EN
  localparam int XL = 2;
`else
  localparam int XL = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        pulse0 = 1'b0, pulse1 = 1'b0;
  logic        ready0 = 1'b0;
  logic        ready1 = 1'b1;
  logic        v0, ov0, to0, v1, ov1, to1;
  logic [15:0] h0, p0, pc0, pc1;
  logic [3:0]  h1, p1;
  int          cmp = 0;
  int          err = 0;

  always #5 clk = ~clk;

  pulse_monitor #(.CNT_W(16), .SYNC_STAGES(2), .TIMEOUT(50)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .pulse_in(pulse0), .meas_ready(ready0), .meas_valid(v0),
    .high_cnt(h0), .period_cnt(p0), .pulse_count(pc0), .overflow(ov0), .timeout(to0)
  );

  pulse_monitor #(.CNT_W(4), .SYNC_STAGES(2), .TIMEOUT(50)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .pulse_in(pulse1), .meas_ready(ready1), .meas_valid(v1),
    .high_cnt(h1), .period_cnt(p1), .pulse_count(pc1), .overflow(ov1), .timeout(to1)
  );

  // Drive a level for n cycles; called and returning at posedge+1.
  task automatic drive0(input logic lvl, input int n);
    pulse0 = lvl;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive1(input logic lvl, input int n);
    pulse1 = lvl;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic apply_reset();
    rst_n  = 1'b0;
    pulse0 = 1'b0;
    pulse1 = 1'b0;
    ready0 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    cmp++; if (v0 !== 1'b0) begin err++; $display("FAIL reset_valid: got %b want 0", v0); end
    cmp++; if (h0 !== 16'd0 || p0 !== 16'd0) begin
      err++; $display("FAIL reset_counts: got %0d/%0d want 0/0", h0, p0); end
    cmp++; if (pc0 !== 16'd0 || ov0 !== 1'b0 || to0 !== 1'b0) begin
      err++; $display("FAIL reset_flags: got pc=%0d ov=%b to=%b want 0", pc0, ov0, to0); end
    apply_reset();
    cmp++; if (v0 !== 1'b0 || pc0 !== 16'd0 || v1 !== 1'b0) begin
      err++; $display("FAIL reset_release: got v0=%b pc0=%0d v1=%b want 0", v0, pc0, v1); end
  endtask

  task automatic test_steady();
    int          nv;
    int          vidx[8];
    logic [15:0] fh, fp, fpc;
    nv = 0; fh = '0; fp = '0; fpc = '0;
    apply_reset();
    ready0 = 1'b1;
    fork
      begin
        repeat (4) begin drive0(1'b1, 5); drive0(1'b0, 15); end
        drive0(1'b1, 5);
        drive0(1'b0, 5);
      end
      begin
        for (int i = 0; i < 90; i++) begin
          @(posedge clk); #1;
          if (v0) begin
            if (nv == 0) begin fh = h0; fp = p0; fpc = pc0; end
            if (nv < 8) vidx[nv] = i;
            nv++;
          end
        end
      end
    join
    cmp++; if (nv !== 4) begin err++; $display("FAIL steady_nvalid: got %0d want 4", nv); end
    cmp++; if (fh !== 16'd5) begin err++; $display("FAIL steady_high: got %0d want 5", fh); end
    cmp++; if (fp !== 16'd20) begin err++; $display("FAIL steady_period: got %0d want 20", fp); end
    cmp++; if (fpc !== 16'd1) begin err++; $display("FAIL steady_first_count: got %0d want 1", fpc); end
    for (int k = 1; k < 4; k++) begin
      if (k < nv) begin
        cmp++;
        if (vidx[k] - vidx[k-1] !== 20) begin
          err++; $display("FAIL steady_spacing%0d: got %0d want 20", k, vidx[k] - vidx[k-1]);
        end
      end
    end
    cmp++; if (pc0 !== 16'd4) begin err++; $display("FAIL steady_count: got %0d want 4", pc0); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    ready0 = 1'b0;
    drive0(1'b1, 4); drive0(1'b0, 10);
    drive0(1'b1, 6);
    cmp++; if (v0 !== 1'b1 || h0 !== 16'd4 || p0 !== 16'd14 || pc0 !== 16'd1) begin
      err++; $display("FAIL bp_first: got v=%b %0d/%0d pc=%0d want 1 4/14 pc=1", v0, h0, p0, pc0);
    end
    drive0(1'b0, 10);
    drive0(1'b1, 8); drive0(1'b0, 10);
    drive0(1'b1, 5);
    cmp++; if (v0 !== 1'b1) begin err++; $display("FAIL bp_valid_held: got %b want 1", v0); end
    cmp++; if (h0 !== 16'd8 || p0 !== 16'd18) begin
      err++; $display("FAIL bp_latest: got %0d/%0d want 8/18", h0, p0); end
    cmp++; if (pc0 !== 16'd3) begin err++; $display("FAIL bp_count: got %0d want 3", pc0); end
    ready0 = 1'b1;
    @(posedge clk); #1;
    ready0 = 1'b0;
    cmp++; if (v0 !== 1'b0) begin err++; $display("FAIL bp_drop: got %b want 0", v0); end
    cmp++; if (h0 !== 16'd8) begin err++; $display("FAIL bp_hold: got %0d want 8", h0); end
  endtask

  task automatic test_timeout();
    apply_reset();
    ready0 = 1'b0;
    drive0(1'b1, 52 + XL);
    cmp++; if (to0 !== 1'b0) begin err++; $display("FAIL to_early: got %b want 0", to0); end
    drive0(1'b1, 1);
    cmp++; if (to0 !== 1'b1) begin err++; $display("FAIL to_set: got %b want 1", to0); end
    cmp++; if (v0 !== 1'b0 || pc0 !== 16'd0) begin
      err++; $display("FAIL to_nocapture: got v=%b pc=%0d want 0/0", v0, pc0); end
    drive0(1'b0, 5);
    drive0(1'b1, 5);
    cmp++; if (to0 !== 1'b0) begin err++; $display("FAIL to_clear: got %b want 0", to0); end
    drive0(1'b0, 15);
    drive0(1'b1, 5);
    cmp++; if (v0 !== 1'b1 || h0 !== 16'd5 || p0 !== 16'd20 || pc0 !== 16'd1) begin
      err++; $display("FAIL to_recover: got v=%b %0d/%0d pc=%0d want 1 5/20 pc=1", v0, h0, p0, pc0);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    cmp++; if (ov1 !== 1'b0) begin err++; $display("FAIL ovf_initial: got %b want 0", ov1); end
    drive1(1'b1, 3); drive1(1'b0, 20);
    drive1(1'b1, 3); drive1(1'b0, XL);
    cmp++; if (v1 !== 1'b1 || h1 !== 4'd3 || p1 !== 4'd15) begin
      err++; $display("FAIL ovf_sat: got v=%b %0d/%0d want 1 3/15", v1, h1, p1); end
    cmp++; if (ov1 !== 1'b1) begin err++; $display("FAIL ovf_set: got %b want 1", ov1); end
    drive1(1'b0, 5 - XL);
    drive1(1'b1, 3); drive1(1'b0, XL);
    cmp++; if (v1 !== 1'b1 || h1 !== 4'd3 || p1 !== 4'd8 || pc1 !== 16'd2) begin
      err++; $display("FAIL ovf_normal: got v=%b %0d/%0d pc=%0d want 1 3/8 pc=2", v1, h1, p1, pc1);
    end
    cmp++; if (ov1 !== 1'b1 || to1 !== 1'b0) begin
      err++; $display("FAIL ovf_sticky: got ov=%b to=%b want 1/0", ov1, to1); end
    drive1(1'b0, 5);
  endtask

  task automatic test_async_reset();
    ready0 = 1'b0;
    drive0(1'b1, 5); drive0(1'b0, 15); drive0(1'b1, 5);
    cmp++; if (v0 !== 1'b1 || h0 !== 16'd5 || pc0 !== 16'd1) begin
      err++; $display("FAIL ar_setup: got v=%b h=%0d pc=%0d want 1/5/1", v0, h0, pc0); end
    #2 rst_n = 1'b0;
    #1;
    cmp++; if (v0 !== 1'b0 || h0 !== 16'd0 || p0 !== 16'd0 || pc0 !== 16'd0) begin
      err++; $display("FAIL ar_immediate: got v=%b %0d/%0d pc=%0d want 0", v0, h0, p0, pc0); end
    cmp++; if (ov1 !== 1'b0 || pc1 !== 16'd0) begin
      err++; $display("FAIL ar_dut1: got ov=%b pc=%0d want 0/0", ov1, pc1); end
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    drive0(1'b1, 6); drive0(1'b0, 10);
    drive0(1'b1, 5); drive0(1'b0, 15);
    cmp++; if (v0 !== 1'b0 || pc0 !== 16'd0) begin
      err++; $display("FAIL ar_partial: got v=%b pc=%0d want 0/0", v0, pc0); end
    drive0(1'b1, 5);
    cmp++; if (v0 !== 1'b1 || h0 !== 16'd5 || p0 !== 16'd20 || pc0 !== 16'd1) begin
      err++; $display("FAIL ar_first: got v=%b %0d/%0d pc=%0d want 1 5/20 pc=1", v0, h0, p0, pc0);
    end
  endtask

  task automatic test_glitch();
    apply_reset();
    ready0 = 1'b1;
    drive0(1'b1, 5); drive0(1'b0, 6);
    drive0(1'b1, 2); drive0(1'b0, 7);
`ifdef PULSE_MONITOR_DEGLITCH_EN
    cmp++; if (pc0 !== 16'd0) begin err++; $display("FAIL glitch_mid: got pc=%0d want 0", pc0); end
    drive0(1'b1, 5);
    cmp++; if (h0 !== 16'd5 || p0 !== 16'd20 || pc0 !== 16'd1) begin
      err++; $display("FAIL glitch_final: got %0d/%0d pc=%0d want 5/20 pc=1", h0, p0, pc0); end
`else
    cmp++; if (h0 !== 16'd5 || p0 !== 16'd11 || pc0 !== 16'd1) begin
      err++; $display("FAIL glitch_mid: got %0d/%0d pc=%0d want 5/11 pc=1", h0, p0, pc0); end
    drive0(1'b1, 5);
    cmp++; if (h0 !== 16'd2 || p0 !== 16'd9 || pc0 !== 16'd2) begin
      err++; $display("FAIL glitch_final: got %0d/%0d pc=%0d want 2/9 pc=2", h0, p0, pc0); end
`endif
  endtask

  initial begin
    test_reset();
    test_steady();
    test_backpressure();
    test_timeout();
    test_overflow();
    test_async_reset();
    test_glitch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, want finish before 1000000");
    $fatal(1, "watchdog expired");
  end

endmodule
